// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer that turns bit-reversed FFT output into a natural-order valid/ready stream.
// Optional in_last frame-length checking is enabled with `BITREV_FRAME_CHECK_EN.
module fft_bitrev_reorder #(
  parameter int unsigned LOG2N = 4,
  parameter int unsigned DW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             frame_err
);

  localparam int unsigned N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  sample_t mem [2][N];

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wb;
  logic             rb;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic             err_q;

  logic    wr_hs;
  logic    rd_hs;
  logic    wr_end;
  logic    rd_end;
  logic    wr_done;
  logic    rd_done;
  logic    early_last;
  logic    frame_bad;
  sample_t rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  assign in_ready = !full[wb];
  assign wr_hs    = in_valid && in_ready;
  assign rd_hs    = full[rb] && out_ready;
  assign wr_end   = (wr_cnt == LAST_IDX);
  assign rd_end   = (rd_cnt == LAST_IDX);
  assign wr_done  = wr_hs && wr_end;
  assign rd_done  = rd_hs && rd_end;

`ifdef BITREV_FRAME_CHECK_EN
  // Early in_last drops the partial frame; a missing in_last only flags the error.
  assign early_last = in_last && !wr_end;
  assign frame_bad  = wr_hs && (in_last != wr_end);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign early_last     = 1'b0;
  assign frame_bad      = 1'b0;
`endif

  // Set and clear always hit different banks when they coincide.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wb] = 1'b1;
    if (rd_done) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 2'b00;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      full  <= full_nxt;
      err_q <= err_q | frame_bad;
      if (wr_hs) begin
        if (wr_end || early_last) wr_cnt <= '0;
        else                      wr_cnt <= wr_cnt + LOG2N'(1);
      end
      if (wr_done) wb <= ~wb;
      if (rd_hs) begin
        if (rd_end) rd_cnt <= '0;
        else        rd_cnt <= rd_cnt + LOG2N'(1);
      end
      if (rd_done) rb <= ~rb;
    end
  end

  // Bank storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      mem[wb][bitrev(wr_cnt)] <= '{re: in_re, im: in_im};
    end
  end

  assign rd_word   = mem[rb][rd_cnt];
  assign out_valid = full[rb];
  assign out_re    = full[rb] ? rd_word.re : '0;
  assign out_im    = full[rb] ? rd_word.im : '0;
  assign out_index = rd_cnt;
  assign out_last  = full[rb] && rd_end;
  assign frame_err = err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder (LOG2N = 4, DW = 16).
module tb_fft_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [3:0]  out_index;
  logic        out_last;
  logic        frame_err;

  fft_bitrev_reorder #(.LOG2N(4), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  idx;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_out = 0;
  int in_stall = 0;
  int stream_mark = -1;
  int first_cyc = 0;
  int last_cyc = 0;

  logic [31:0] mframe [16];
  int mcnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] brev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // Reference model and output comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt = 0;
      q.delete();
    end else begin
      cyc++;
      if (in_valid && !in_ready) in_stall++;
      if (in_valid && in_ready) begin
        mframe[brev4(4'(mcnt))] = {in_re, in_im};
`ifdef BITREV_FRAME_CHECK_EN
        if (in_last && mcnt != 15) mcnt = -1;
`endif
        if (mcnt == 15) begin
          for (int i = 0; i < 16; i++)
            q.push_back('{re: mframe[i][31:16], im: mframe[i][15:0], idx: 4'(i)});
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", 64'(out_index), 64'hffff);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("out_re", 64'(out_re), 64'(e.re));
          check_eq("out_im", 64'(out_im), 64'(e.im));
          check_eq("out_index", 64'(out_index), 64'(e.idx));
          check_eq("out_last", 64'(out_last), 64'(e.idx == 4'd15));
        end
        if (n_out == stream_mark) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
      end
    end
  end

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    bit acc = 0;
    int guard = 0;
    in_re = re; in_im = im; in_last = last; in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 300) begin
        check_eq("send_timeout", 64'(guard), 64'd0);
        acc = 1;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while ((q.size() != 0 || out_valid) && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_eq(tag, 64'(q.size() == 0 && !out_valid), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_out_last"}, 64'(out_last), 64'd0);
    check_eq({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check_eq({tag, "_out_re"}, 64'(out_re), 64'd0);
    check_eq({tag, "_out_im"}, 64'(out_im), 64'd0);
    check_eq({tag, "_out_index"}, 64'(out_index), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] hold_re;
    logic [3:0]  hold_idx;
    bit stable;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ordering and first-sample latency
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      v = 16'(brev4(4'(k))) << 8;
      send(v, -v, k == 15);
      if (k == 14) check_eq("pre_valid", 64'(out_valid), 64'd0);
    end
    idle();
    check_eq("latency_valid", 64'(out_valid), 64'd1);
    check_eq("latency_index", 64'(out_index), 64'd0);
    check_eq("latency_re", 64'(out_re), 64'd0);
    wait_drain("order_drain");

    // Continuous streaming of four frames
    stream_mark = n_out;
    begin
      int stall0 = in_stall;
      for (int f = 0; f < 4; f++)
        for (int k = 0; k < 16; k++)
          send(16'($urandom), 16'($urandom), k == 15);
      idle();
      check_eq("stream_in_ready", 64'(in_stall - stall0), 64'd0);
    end
    wait_drain("stream_drain");
    check_eq("stream_count", 64'(n_out - stream_mark), 64'd64);
    check_eq("stream_span", 64'(last_cyc - first_cyc), 64'd63);
    stream_mark = -1;

    // Back-pressure with both banks filled
    out_ready = 1'b0;
    for (int k = 0; k < 32; k++)
      send(16'h2000 + 16'(k), 16'h3000 - 16'(k), (k % 16) == 15);
    send_blocked_probe: begin
      in_valid = 1'b1;
      in_re = 16'hdead; in_im = 16'hbeef; in_last = 1'b0;
      @(negedge clk);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_first_re", 64'(out_re), 64'(q[0].re));
      hold_re = out_re;
      hold_idx = out_index;
      idle();
    end
    stable = 1;
    repeat (38) begin
      @(negedge clk);
      if (out_re !== hold_re || out_index !== hold_idx || out_last !== 1'b0 || !out_valid) stable = 0;
    end
    check_eq("bp_stable", 64'(stable), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("bp_drain");
    check_eq("bp_in_ready_after", 64'(in_ready), 64'd1);

    // Reset in the middle of a frame
    for (int k = 0; k < 7; k++) send(16'h7700 + 16'(k), 16'h6600 + 16'(k), 1'b0);
    do_reset();
    check_reset_outputs("post_rst");
    for (int k = 0; k < 16; k++) send(16'h1000 + 16'(k), 16'h0100 * 16'(k), k == 15);
    idle();
    wait_drain("rst_drain");

    // Early in_last on the 10th sample
    for (int k = 0; k < 10; k++) send(16'h4000 + 16'(k), 16'h0, k == 9);
`ifdef BITREV_FRAME_CHECK_EN
    check_eq("fc_err_set", 64'(frame_err), 64'd1);
`else
    check_eq("fc_err_set", 64'(frame_err), 64'd0);
`endif
    for (int k = 0; k < 16; k++) begin
      send(16'h5000 + 16'(k), 16'h0F00 + 16'(k), k == 15);
`ifdef BITREV_FRAME_CHECK_EN
      if (k == 5) check_eq("fc_first_out", 64'(out_valid), 64'd0);
`else
      if (k == 5) check_eq("fc_first_out", 64'(out_valid), 64'd1);
`endif
    end
    idle();
    wait_drain("fc_drain");
`ifdef BITREV_FRAME_CHECK_EN
    check_eq("fc_err_sticky", 64'(frame_err), 64'd1);
`else
    check_eq("fc_err_sticky", 64'(frame_err), 64'd0);
`endif
    do_reset();
    check_eq("fc_err_cleared", 64'(frame_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
